// File: rtl/cp_inserter.sv
// Transmit-side cyclic prefix inserter: buffers one OFDM symbol, then replays
// its last Ng samples as the prefix followed by the full nfft-sample body.
module cp_inserter #(
    parameter int AW = 9,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          go,
    input  logic [11:0]   Ng,
    input  logic [11:0]   nfft,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_i,
    input  logic [DW-1:0] in_q,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_i,
    output logic [DW-1:0] out_q,
    output logic          out_cp,
    output logic          out_last,
    output logic          done,
    output logic          err,
    output logic [1:0]    dbg_state
);

    // Handshake: a sample moves only on a rising clk edge where valid and ready
    // are both 1; input and output sides are independent, and output payload is
    // held stable for as long as out_valid=1 and out_ready=0.

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_FILL = 2'd1,
        S_CP   = 2'd2,
        S_BODY = 2'd3
    } state_t;

    localparam logic [11:0] MAX_N   = 12'(1 << AW);
    localparam logic [AW:0] CNT_ONE = (AW+1)'(1);
    localparam logic [AW:0] CNT_ZERO = '0;

    state_t        state;
    state_t        state_n;
    logic [AW:0]   wr;
    logic [AW:0]   rd;
    logic [AW:0]   ng_q;
    logic [AW:0]   nfft_q;
    logic [AW:0]   last_idx;
    logic          cfg_ok;
    logic          in_xfer;
    logic          out_xfer;
    logic          wr_at_last;
    logic          rd_at_last;

    logic [DW-1:0] mem_i [0:(1<<AW)-1];
    logic [DW-1:0] mem_q [0:(1<<AW)-1];

    assign cfg_ok     = (nfft != 12'd0) && (nfft <= MAX_N) && (Ng <= nfft);
    assign in_xfer    = in_valid && in_ready;
    assign out_xfer   = out_valid && out_ready;
    assign last_idx   = nfft_q - CNT_ONE;
    assign wr_at_last = (wr == last_idx);
    assign rd_at_last = (rd == last_idx);

    // State register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            S_IDLE: begin
                if (go && cfg_ok) begin
                    state_n = S_FILL;
                end
            end
            S_FILL: begin
                if (in_xfer && wr_at_last) begin
                    state_n = (ng_q != CNT_ZERO) ? S_CP : S_BODY;
                end
            end
            S_CP: begin
                if (out_xfer && rd_at_last) begin
                    state_n = S_BODY;
                end
            end
            S_BODY: begin
                if (out_xfer && rd_at_last) begin
                    state_n = S_IDLE;
                end
            end
            default: state_n = S_IDLE;
        endcase
    end

    // Outputs decode from registered state/rd only, so they move on clock edges
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_cp    = 1'b0;
        out_last  = 1'b0;
        case (state)
            S_FILL: in_ready = 1'b1;
            S_CP: begin
                out_valid = 1'b1;
                out_cp    = 1'b1;
            end
            S_BODY: begin
                out_valid = 1'b1;
                out_last  = rd_at_last;
            end
            default: ;
        endcase
    end

    assign out_i     = mem_i[rd[AW-1:0]];
    assign out_q     = mem_q[rd[AW-1:0]];
    assign dbg_state = state;

    // Counters, latched configuration and status pulses
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr     <= '0;
            rd     <= '0;
            ng_q   <= '0;
            nfft_q <= '0;
            done   <= 1'b0;
            err    <= 1'b0;
        end else begin
            done <= (state == S_BODY) && out_xfer && rd_at_last;
            err  <= (state == S_IDLE) && go && !cfg_ok;
            case (state)
                S_IDLE: begin
                    if (go && cfg_ok) begin
                        ng_q   <= Ng[AW:0];
                        nfft_q <= nfft[AW:0];
                        wr     <= '0;
                    end
                end
                S_FILL: begin
                    if (in_xfer) begin
                        wr <= wr + CNT_ONE;
                        if (wr_at_last) begin
                            rd <= (ng_q != CNT_ZERO) ? (nfft_q - ng_q) : CNT_ZERO;
                        end
                    end
                end
                S_CP: begin
                    if (out_xfer) begin
                        rd <= rd_at_last ? CNT_ZERO : (rd + CNT_ONE);
                    end
                end
                S_BODY: begin
                    if (out_xfer) begin
                        rd <= rd + CNT_ONE;
                    end
                end
                default: ;
            endcase
        end
    end

    // Symbol buffer; contents are don't-care after reset
    always_ff @(posedge clk) begin
        if (in_xfer) begin
            mem_i[wr[AW-1:0]] <= in_i;
            mem_q[wr[AW-1:0]] <= in_q;
        end
    end

endmodule

// File: tb/tb_cp_inserter.sv
// Bench for cp_inserter: table of symbol configurations plus random symbols,
// checked against a prefix/body model built from plain index arithmetic.
module tb_cp_inserter;

    localparam int AW = 9;
    localparam int DW = 12;

    logic          clk;
    logic          reset;
    logic          go;
    logic [11:0]   ng_in;
    logic [11:0]   nfft_in;
    logic          in_valid;
    logic          in_ready;
    logic [DW-1:0] in_i;
    logic [DW-1:0] in_q;
    logic          out_valid;
    logic          out_ready;
    logic [DW-1:0] out_i;
    logic [DW-1:0] out_q;
    logic          out_cp;
    logic          out_last;
    logic          done;
    logic          err;
    logic [1:0]    dbg_state;

    int n_cmp;
    int n_mis;

    logic [DW-1:0]   src_i [0:511];
    logic [DW-1:0]   src_q [0:511];
    logic [2*DW+1:0] exp_q [$];

    typedef struct {
        int ng;
        int nfft;
        bit exp_err;
        bit seq_data;
        int base;
        int ready_mode;
        bit go_in_body;
    } vec_t;

    vec_t vecs [0:10];

    cp_inserter #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .reset(reset), .go(go), .Ng(ng_in), .nfft(nfft_in),
        .in_valid(in_valid), .in_ready(in_ready), .in_i(in_i), .in_q(in_q),
        .out_valid(out_valid), .out_ready(out_ready), .out_i(out_i), .out_q(out_q),
        .out_cp(out_cp), .out_last(out_last), .done(done), .err(err),
        .dbg_state(dbg_state)
    );

    // Clock
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_mis++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, expv, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic load_src(input int nfft, input bit seq_data, input int base);
        for (int k = 0; k < nfft; k++) begin
            src_i[k] = seq_data ? DW'(base + k) : DW'($urandom);
            src_q[k] = DW'($urandom);
        end
    endtask

    // Called at a negedge; leaves the bench at the negedge after go was sampled.
    task automatic start_go(input int ng, input int nfft, input bit exp_err);
        go      = 1'b1;
        ng_in   = 12'(ng);
        nfft_in = 12'(nfft);
        step();
        go      = 1'b0;
        ng_in   = 12'($urandom);
        nfft_in = 12'($urandom);
        chk("go_err", {31'd0, err}, {31'd0, exp_err});
        chk("go_in_ready", {31'd0, in_ready}, {31'd0, !exp_err});
        chk("go_done_clear", {31'd0, done}, 32'd0);
        if (exp_err) begin
            step();
            chk("err_one_cycle", {31'd0, err}, 32'd0);
            chk("err_idle_ready", {31'd0, in_ready}, 32'd0);
            chk("err_idle_valid", {31'd0, out_valid}, 32'd0);
        end
    endtask

    task automatic fill(input int nfft, input bit gaps);
        int k = 0;
        int budget = nfft * 4 + 20;
        while (k < nfft && budget > 0) begin
            in_valid = gaps ? 1'($urandom_range(0, 1)) : 1'b1;
            in_i     = src_i[k];
            in_q     = src_q[k];
            if (in_valid && in_ready) k++;
            if (out_valid) chk("fill_out_valid", {31'd0, out_valid}, 32'd0);
            budget--;
            step();
        end
        if (k < nfft) chk("fill_timeout", 32'(k), 32'(nfft));
        // Keep offering junk: it must be held off outside FILL.
        in_valid = 1'b1;
        in_i     = DW'($urandom);
        in_q     = DW'($urandom);
        chk("first_cp_latency", {31'd0, out_valid}, 32'd1);
        chk("fill_end_ready", {31'd0, in_ready}, 32'd0);
    endtask

    task automatic drain(input int ng, input int nfft, input int mode, input bit go_in_body);
        int cycles = 0;
        int budget = (ng + nfft) * 4 + 20;
        logic [2*DW+1:0] exp_v;
        logic [2*DW+1:0] prev_v = '0;
        bit prev_stall = 1'b0;
        exp_q.delete();
        for (int k = 0; k < ng + nfft; k++) begin
            int idx = (k < ng) ? (nfft - ng + k) : (k - ng);
            exp_q.push_back({1'(k < ng), 1'(k == ng + nfft - 1), src_i[idx], src_q[idx]});
        end
        while (exp_q.size() > 0 && budget > 0) begin
            case (mode)
                0: out_ready = 1'b1;
                1: out_ready = (cycles % 3 == 0);
                default: out_ready = 1'($urandom_range(0, 1));
            endcase
            if (go_in_body && exp_q.size() < nfft && cycles % 2 == 1) begin
                go = 1'b1; ng_in = 12'd0; nfft_in = 12'd1;
            end else begin
                go = 1'b0;
            end
            chk("drain_valid", {31'd0, out_valid}, 32'd1);
            chk("drain_in_ready", {31'd0, in_ready}, 32'd0);
            chk("drain_done", {31'd0, done}, 32'd0);
            if (prev_stall)
                chk("stall_stable", 32'({out_cp, out_last, out_i, out_q}), 32'(prev_v));
            if (out_valid && out_ready) begin
                exp_v = exp_q.pop_front();
                chk("sample", 32'({out_cp, out_last, out_i, out_q}), 32'(exp_v));
            end
            prev_stall = out_valid && !out_ready;
            prev_v     = {out_cp, out_last, out_i, out_q};
            cycles++;
            budget--;
            step();
        end
        go = 1'b0;
        out_ready = 1'($urandom_range(0, 1));
        if (exp_q.size() > 0) chk("drain_timeout", 32'(exp_q.size()), 32'd0);
        if (mode == 0) chk("emit_cycles", 32'(cycles), 32'(ng + nfft));
        chk("done_pulse", {31'd0, done}, 32'd1);
        chk("end_valid", {31'd0, out_valid}, 32'd0);
        chk("end_last", {31'd0, out_last}, 32'd0);
    endtask

    task automatic run_symbol(input int ng, input int nfft, input bit exp_err, input bit seq_data,
                              input int base, input int mode, input bit go_in_body, input bit gaps);
        start_go(ng, nfft, exp_err);
        if (!exp_err) begin
            load_src(nfft, seq_data, base);
            fill(nfft, gaps);
            drain(ng, nfft, mode, go_in_body);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_mis = 0;
        vecs[0]  = '{ng: 2,   nfft: 8,   exp_err: 0, seq_data: 1, base: 1,  ready_mode: 0, go_in_body: 0};
        vecs[1]  = '{ng: 0,   nfft: 4,   exp_err: 0, seq_data: 1, base: 10, ready_mode: 0, go_in_body: 0};
        vecs[2]  = '{ng: 2,   nfft: 8,   exp_err: 0, seq_data: 1, base: 1,  ready_mode: 1, go_in_body: 0};
        vecs[3]  = '{ng: 9,   nfft: 8,   exp_err: 1, seq_data: 0, base: 0,  ready_mode: 0, go_in_body: 0};
        vecs[4]  = '{ng: 0,   nfft: 0,   exp_err: 1, seq_data: 0, base: 0,  ready_mode: 0, go_in_body: 0};
        vecs[5]  = '{ng: 2,   nfft: 8,   exp_err: 0, seq_data: 1, base: 1,  ready_mode: 0, go_in_body: 1};
        vecs[6]  = '{ng: 128, nfft: 512, exp_err: 0, seq_data: 1, base: 0,  ready_mode: 0, go_in_body: 0};
        vecs[7]  = '{ng: 8,   nfft: 8,   exp_err: 0, seq_data: 0, base: 0,  ready_mode: 2, go_in_body: 0};
        vecs[8]  = '{ng: 0,   nfft: 512, exp_err: 0, seq_data: 0, base: 0,  ready_mode: 2, go_in_body: 0};
        vecs[9]  = '{ng: 1,   nfft: 1,   exp_err: 0, seq_data: 0, base: 0,  ready_mode: 0, go_in_body: 0};
        vecs[10] = '{ng: 5,   nfft: 513, exp_err: 1, seq_data: 0, base: 0,  ready_mode: 0, go_in_body: 0};

        // Reset
        reset = 1'b0; go = 1'b0; ng_in = '0; nfft_in = '0;
        in_valid = 1'b0; in_i = '0; in_q = '0; out_ready = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_outputs", 32'({in_ready, out_valid, out_cp, out_last, done, err}), 32'd0);
        reset = 1'b1;
        step();
        chk("idle_outputs", 32'({in_ready, out_valid, done, err}), 32'd0);

        // Table-driven symbols, each go issued in the cycle that carries the previous done
        foreach (vecs[v])
            run_symbol(vecs[v].ng, vecs[v].nfft, vecs[v].exp_err, vecs[v].seq_data,
                       vecs[v].base, vecs[v].ready_mode, vecs[v].go_in_body, 1'b0);

        // Random symbols with input gaps and random backpressure
        for (int r = 0; r < 10; r++) begin
            int n = $urandom_range(1, 64);
            run_symbol($urandom_range(0, n), n, 1'b0, 1'b0, 0, 2, 1'($urandom_range(0, 1)), 1'b1);
        end

        // Reset during the prefix abandons the symbol at once
        start_go(2, 8, 1'b0);
        load_src(8, 1'b1, 1);
        fill(8, 1'b0);
        out_ready = 1'b1;
        step();
        #2 reset = 1'b0;
        #1 chk("rst_mid_valid", 32'({out_valid, out_cp, in_ready}), 32'd0);
        for (int c = 0; c < 3; c++) begin
            step();
            chk("rst_no_done", {31'd0, done}, 32'd0);
        end
        reset = 1'b1;
        step();
        chk("post_rst_done", {31'd0, done}, 32'd0);
        run_symbol(1, 2, 1'b0, 1'b1, 5, 0, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

    // Global watchdog
    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/cp_inserter.md
Name: cp_inserter

Overview:
Transmit-side cyclic prefix inserter. It is the counterpart of the receive-side CP-based CFO estimator.
- Buffers one OFDM symbol of nfft complex time-domain samples.
- Emits the last Ng samples (the cyclic prefix), then the full nfft-sample body, on a valid/ready stream.
- Sits between the IFFT output and the DAC/channel model, and feeds the estimator's test benches.

Parameters:
AW, 9, symbol buffer address width; buffer depth and maximum nfft = 2^AW (512).
DW, 12, width of each I and Q sample component.

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous reset, active-low (0 = reset)
go  in  1  start one symbol; sampled in IDLE only
Ng  in  12  cyclic prefix length; latched on accepted go
nfft  in  12  symbol length; latched on accepted go
in_valid  in  1  input sample valid
in_ready  out  1  block accepts input sample
in_i  in  DW  input sample, real part
in_q  in  DW  input sample, imaginary part
out_valid  out  1  output sample valid
out_ready  in  1  downstream accepts output sample
out_i  out  DW  output sample, real part
out_q  out  DW  output sample, imaginary part
out_cp  out  1  current output sample belongs to the prefix
out_last  out  1  current output sample is the last of the symbol (body index nfft-1)
done  out  1  one-cycle pulse: symbol fully emitted
err  out  1  one-cycle pulse: go rejected because of an illegal configuration

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE; wr/rd counters go to 0.
  - in_ready, out_valid, out_cp, out_last, done and err all go to 0.
  - Buffer contents are not cleared and are don't-care.
- A transfer happens only when valid and ready are both 1 on a rising clk edge; this applies independently on the input and output sides.
- FSM states: IDLE, FILL, CP, BODY.
- IDLE:
  - in_ready=0 and out_valid=0.
  - On go=1, the config is legal when 1 <= nfft <= 2^AW and Ng <= nfft.
  - Legal config: latch Ng and nfft, clear the write counter, go to FILL next cycle.
  - Illegal config: pulse err for one cycle and stay in IDLE.
- FILL:
  - in_ready=1.
  - Each input transfer writes buf[wr] and increments wr.
  - On the transfer with wr == nfft-1:
    - If Ng > 0: rd = nfft-Ng, go to CP.
    - If Ng == 0: rd = 0, go to BODY.
- CP:
  - in_ready=0, out_valid=1, out_cp=1, out_i/out_q = buf[rd].
  - Each output transfer increments rd.
  - On the transfer with rd == nfft-1: rd = 0, go to BODY.
- BODY:
  - out_valid=1, out_cp=0, out_i/out_q = buf[rd].
  - out_last=1 when rd == nfft-1.
  - Each output transfer increments rd.
  - On the last transfer: done=1 in the following cycle, then return to IDLE.
- Output data path: buffer read is combinational from the registered rd. out_i/out_q/out_cp/out_last therefore change only on a clock edge and stay stable while out_valid=1 and out_ready=0.
- Latency:
  - The first CP sample is valid in the cycle after the last input transfer.
  - Total output count per symbol is Ng+nfft.
  - With out_ready held at 1, emission takes exactly Ng+nfft cycles.
- go outside IDLE is ignored; it never restarts or corrupts a symbol in progress.
- The Ng/nfft inputs may change freely after an accepted go; only the latched copies are used.
- Ng == nfft is legal: the prefix is the whole symbol, giving 2*nfft outputs.
- Counters are AW+1 bits, so nfft = 2^AW needs no wrap. The compare at nfft-1 is exact; no modulo arithmetic is used.
- Reset asserted mid-symbol: the symbol is abandoned immediately, outputs drop in the same cycle (asynchronous), and no done pulse is generated.
- in_valid while in_ready=0 is held off; no sample is dropped or written.
- Back-to-back symbols: the next go can be accepted in the IDLE cycle that coincides with the done pulse.

Test Plan:
1. Nominal: Ng=2, nfft=8, go, inputs 1..8, out_ready=1 -> output 7,8,1,2,3,4,5,6,7,8. out_cp=1 on the first two, out_last=1 on the final 8. done pulses once, in the cycle after the final transfer.
2. No prefix: Ng=0, nfft=4, inputs 10..13 -> output 10,11,12,13 with out_cp never set. done pulses after 4 output cycles.
3. Backpressure: case 1 with out_ready toggling 1,0,0,1,... -> identical 10-sample sequence. out_i/out_q are held stable on every stalled cycle, and in_ready stays 0 throughout CP and BODY.
4. Illegal and ignored go:
   - Ng=9, nfft=8 -> err pulses for 1 cycle, state stays IDLE, in_ready stays 0.
   - nfft=0 -> err.
   - go pulsed during BODY -> no effect on the output sequence.
5. Maximum size: Ng=128, nfft=512, inputs 0..511 -> output 384..511 then 0..511, 640 samples total, out_last only on sample 511.
6. Reset mid-operation: reset=0 during CP of case 1 -> out_valid=0 immediately, no done. After release, go with Ng=1, nfft=2 and inputs 5,6 -> output 6,5,6.
